sdram_region_scheduler: RTL and testbench

SDRAM_REGION_SCHEDULER -- requirements
Module: sdram_region_scheduler

---
 rtl/sdram_region_scheduler_pkg.sv | 23 ++
 rtl/sched_rr_arbiter.sv | 62 ++++++
 rtl/sdram_region_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sdram_region_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_region_scheduler_pkg.sv
// Shared command and state encodings for the SDRAM region scheduler.
// Command codes and FSM state codes are kept identical so a state maps directly onto the bus command.
package sdram_region_scheduler_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic [1:0] state_cmd(input state_t s);
        case (s)
            ST_READ:  return CMD_READ;
            ST_WRITE: return CMD_WRITE;
            default:  return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sched_rr_arbiter.sv
// Channel arbiter: request vector in, one-hot grant out.
// Build option SDRAM_SCHED_RR_EN selects round-robin; otherwise fixed priority (lowest index wins).
module sched_rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [2:0]        grant_idx,
    output logic              any
);

    logic [2:0] start;
    logic [2:0] first;
    logic [2:0] next_start;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic       hi_any;
    logic       lo_any;

    // Channels at or above the search start beat the wrapped-around ones.
    always_comb begin
`ifdef SDRAM_SCHED_RR_EN
        first = start;
`else
        first = 3'd0;
`endif
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = 3'd0;
        lo_idx = 3'd0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req[c]) begin
                if (3'(c) >= first) begin
                    hi_any = 1'b1;
                    hi_idx = 3'(c);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = 3'(c);
                end
            end
        end
        any       = hi_any | lo_any;
        grant_idx = hi_any ? hi_idx : lo_idx;
        grant     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant[c] = any && (grant_idx == 3'(c));
        end
        next_start = (grant_idx == 3'(NUM_CH - 1)) ? 3'd0 : grant_idx + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start <= 3'd0;
        end else begin
            start <= (advance && any) ? next_start : start;
        end
    end

endmodule

// File: rtl/sdram_region_scheduler.sv
// Schedules per-channel SDRAM bursts (read fill / write-back) over fixed address regions.
// Build option: define SDRAM_SCHED_RR_EN for round-robin channel arbitration.
module sdram_region_scheduler
    import sdram_region_scheduler_pkg::*;
#(
    parameter int                       NUM_CH   = 2,
    parameter int                       ADDR_W   = 22,
    parameter int                       DATA_W   = 32,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE  = {22'h20000, 22'h0},
    parameter logic [NUM_CH*ADDR_W-1:0] CH_WORDS = {22'd1536000, 22'd96000},
    parameter logic [NUM_CH*8-1:0]      CH_BURST = {8'd128, 8'd8}
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_n,
    input  logic                     i_SDRAM_Requested,
    output logic                     o_SDRAM_Yield,
    input  logic                     i_Data_Read_Valid,
    input  logic                     i_Data_Write_Done,
    input  logic [NUM_CH-1:0]        i_Rd_Empty,
    input  logic [NUM_CH-1:0]        i_Wb_Empty,
    input  logic [NUM_CH-1:0]        i_Wb_Full,
    input  logic [NUM_CH*DATA_W-1:0] i_Wb_Data,
    output logic [DATA_W-1:0]        o_Data_Write,
    output logic [NUM_CH-1:0]        o_Rd_Wrreq,
    output logic [NUM_CH-1:0]        o_Wb_Rdreq,
    output logic [1:0]               o_Command,
    output logic [ADDR_W-1:0]        o_Data_Address,
    output logic [2:0]               o_Chan
);

    function automatic logic [ADDR_W-1:0] base_of(input int c);
        return CH_BASE[c*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] words_of(input int c);
        return CH_WORDS[c*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [7:0] burst_of(input int c);
        return CH_BURST[c*8 +: 8];
    endfunction

    // The end-of-region sum needs one extra bit so a region ending at the top of memory still wraps.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p, input int c);
        logic [ADDR_W:0] sum;
        logic [ADDR_W:0] lim;
        sum = {1'b0, p} + (ADDR_W+1)'(burst_of(c));
        lim = {1'b0, base_of(c)} + {1'b0, words_of(c)};
        return (sum == lim) ? base_of(c) : sum[ADDR_W-1:0];
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [2:0]          chan;
    logic [7:0]          count;
    logic [ADDR_W-1:0]   ptr [NUM_CH];

    logic [NUM_CH-1:0]   rd_elig;
    logic [NUM_CH-1:0]   arb_req;
    logic [NUM_CH-1:0]   grant;
    logic [NUM_CH-1:0]   chan_sel;
    logic [2:0]          grant_idx;
    logic                grant_any;
    logic                arb_open;
    logic                strobe;
    logic                last;
    logic [ADDR_W-1:0]   g_addr;
    logic [7:0]          g_cnt;
    logic                g_rd;

    always_comb begin
        rd_elig  = i_Rd_Empty & i_Wb_Empty;
        arb_open = (state == ST_IDLE) && !i_SDRAM_Requested;
        arb_req  = arb_open ? (rd_elig | i_Wb_Full) : '0;
    end

    sched_rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .clk      (i_Clk),
        .rst_n    (i_Rst_n),
        .req      (arb_req),
        .advance  (arb_open),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (grant_any)
    );

    // Within the granted channel a pending read fill takes precedence over write-back.
    always_comb begin
        g_addr = '0;
        g_cnt  = '0;
        g_rd   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                g_addr = ptr[c];
                g_cnt  = burst_of(c) - 8'd1;
                g_rd   = rd_elig[c];
            end
        end
    end

    always_comb begin
        chan_sel     = '0;
        o_Data_Write = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chan == 3'(c)) begin
                chan_sel[c]  = 1'b1;
                o_Data_Write = i_Wb_Data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        strobe     = 1'b0;
        o_Rd_Wrreq = '0;
        o_Wb_Rdreq = '0;
        case (state)
            ST_IDLE: begin
                if (grant_any) state_nxt = g_rd ? ST_READ : ST_WRITE;
            end
            ST_READ: begin
                if (i_Data_Read_Valid) begin
                    strobe     = 1'b1;
                    o_Rd_Wrreq = chan_sel;
                end
            end
            ST_WRITE: begin
                if (i_Data_Write_Done) begin
                    strobe     = 1'b1;
                    o_Wb_Rdreq = chan_sel;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        last = strobe && (count == 8'd0);
        if (last) state_nxt = ST_IDLE;
        o_Command     = state_cmd(state);
        o_SDRAM_Yield = i_SDRAM_Requested && (state == ST_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Only a finished write-back moves the region pointer; reads refill the same words in place.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            addr  <= '0;
            chan  <= 3'd0;
            count <= 8'd0;
            for (int c = 0; c < NUM_CH; c++) ptr[c] <= base_of(c);
        end else begin
            if ((state == ST_IDLE) && grant_any) begin
                addr  <= g_addr;
                chan  <= grant_idx;
                count <= g_cnt;
            end else if (strobe) begin
                addr  <= addr + ADDR_W'(1);
                count <= count - 8'd1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if ((state == ST_WRITE) && last && (chan == 3'(c))) ptr[c] <= next_ptr(ptr[c], c);
            end
        end
    end

    assign o_Data_Address = addr;
    assign o_Chan         = chan;

endmodule

// File: tb/tb_sdram_region_scheduler.sv
// Scoreboard bench for sdram_region_scheduler: randomized bursts checked against a region-pointer model.
// Honours SDRAM_SCHED_RR_EN in its arbitration model; regions shrunk so pointer wrap occurs quickly.
module tb_sdram_region_scheduler;
    import sdram_region_scheduler_pkg::*;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam logic [NUM_CH*ADDR_W-1:0] T_BASE  = {22'h20000, 22'h0};
    localparam logic [NUM_CH*ADDR_W-1:0] T_WORDS = {22'd512, 22'd32};
    localparam logic [NUM_CH*8-1:0]      T_BURST = {8'd128, 8'd8};
    localparam int M_BASE  [NUM_CH] = '{0, 32'h20000};
    localparam int M_WORDS [NUM_CH] = '{32, 512};
    localparam int M_BURST [NUM_CH] = '{8, 128};

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     sdram_req = 1'b0;
    logic                     rd_valid = 1'b0;
    logic                     wr_done = 1'b0;
    logic [NUM_CH-1:0]        rd_empty = '0;
    logic [NUM_CH-1:0]        wb_empty = '0;
    logic [NUM_CH-1:0]        wb_full = '0;
    logic [DATA_W-1:0]        wb_head [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] wb_data;
    logic                     yield;
    logic [NUM_CH-1:0]        rd_wrreq;
    logic [NUM_CH-1:0]        wb_rdreq;
    logic [1:0]               command;
    logic [ADDR_W-1:0]        data_addr;
    logic [2:0]               chan;
    logic [DATA_W-1:0]        data_write;

    assign wb_data = {wb_head[1], wb_head[0]};

    sdram_region_scheduler #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CH_BASE (T_BASE),
        .CH_WORDS(T_WORDS),
        .CH_BURST(T_BURST)
    ) dut (
        .i_Clk            (clk),
        .i_Rst_n          (rst_n),
        .i_SDRAM_Requested(sdram_req),
        .o_SDRAM_Yield    (yield),
        .i_Data_Read_Valid(rd_valid),
        .i_Data_Write_Done(wr_done),
        .i_Rd_Empty       (rd_empty),
        .i_Wb_Empty       (wb_empty),
        .i_Wb_Full        (wb_full),
        .i_Wb_Data        (wb_data),
        .o_Data_Write     (data_write),
        .o_Rd_Wrreq       (rd_wrreq),
        .o_Wb_Rdreq       (wb_rdreq),
        .o_Command        (command),
        .o_Data_Address   (data_addr),
        .o_Chan           (chan)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int ch; int addr; } word_t;
    typedef struct { logic [1:0] cmd; int ch; int addr; } grant_t;

    word_t  word_q [$];
    grant_t grant_q [$];
    int     m_ptr [NUM_CH];
    int     rr_next = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    bit     mon_on = 1'b0;
    logic [1:0] prev_cmd = CMD_IDLE;

    task automatic check(input string name, input bit ok, input string got, input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, required %s", name, got, want);
    endtask

    // Monitor: a new burst is matched against the grant queue, every FIFO strobe against the word queue.
    always @(negedge clk) begin
        if (mon_on) begin
            if (command != CMD_IDLE && prev_cmd == CMD_IDLE) begin
                grant_t g;
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", 1'b0, $sformatf("cmd=%0d ch=%0d addr=%0h", command, chan, data_addr), "no grant");
                end else begin
                    g = grant_q.pop_front();
                    check("grant", command == g.cmd && int'(chan) == g.ch && int'(data_addr) == g.addr,
                          $sformatf("cmd=%0d ch=%0d addr=%0h", command, chan, data_addr),
                          $sformatf("cmd=%0d ch=%0d addr=%0h", g.cmd, g.ch, g.addr));
                end
            end
            prev_cmd = command;
            if (rd_wrreq != '0 || wb_rdreq != '0) begin
                word_t w;
                logic [NUM_CH-1:0] exp_rd, exp_wb;
                if (word_q.size() == 0) begin
                    check("strobe_unexpected", 1'b0, $sformatf("rd=%b wb=%b addr=%0h", rd_wrreq, wb_rdreq, data_addr), "no strobe");
                end else begin
                    w = word_q.pop_front();
                    exp_rd = w.wr ? '0 : (NUM_CH'(1) << w.ch);
                    exp_wb = w.wr ? (NUM_CH'(1) << w.ch) : '0;
                    check("word", rd_wrreq == exp_rd && wb_rdreq == exp_wb && int'(data_addr) == w.addr &&
                          (!w.wr || data_write == wb_head[w.ch]),
                          $sformatf("rd=%b wb=%b addr=%0h data=%0h", rd_wrreq, wb_rdreq, data_addr, data_write),
                          $sformatf("rd=%b wb=%b addr=%0h data=%0h", exp_rd, exp_wb, w.addr, w.wr ? wb_head[w.ch] : data_write));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One arbitration opportunity: flags offered for one cycle, then the whole burst (or a reset after stop_at words).
    task automatic issue(input logic [NUM_CH-1:0] re, input logic [NUM_CH-1:0] we,
                         input logic [NUM_CH-1:0] wf, input int stop_at, input bit req_mid);
        int ch, start, n, addr0, nw;
        bit rd;
        ch = -1;
`ifdef SDRAM_SCHED_RR_EN
        start = rr_next;
`else
        start = 0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (start + k) % NUM_CH;
            if (ch < 0 && ((re[c] && we[c]) || wf[c])) ch = c;
        end
        rd_empty = re; wb_empty = we; wb_full = wf;
        if (ch < 0) begin
            step();
            rd_empty = '0; wb_empty = '0; wb_full = '0;
            @(negedge clk);
            check("no_grant", command == CMD_IDLE, $sformatf("cmd=%0d", command), "cmd=0");
            step();
            return;
        end
        rd = re[ch] && we[ch];
        n = M_BURST[ch];
        addr0 = m_ptr[ch];
        nw = (stop_at > 0) ? stop_at : n;
        grant_q.push_back('{cmd: rd ? CMD_READ : CMD_WRITE, ch: ch, addr: addr0});
        for (int i = 0; i < nw; i++) word_q.push_back('{wr: !rd, ch: ch, addr: addr0 + i});
        rr_next = (ch + 1) % NUM_CH;
        step();
        rd_empty = '0; wb_empty = '0; wb_full = '0;
        for (int i = 0; i < nw; i++) begin
            if ($urandom_range(3) == 0) begin
                if (rd) wr_done = 1'b1; else rd_valid = 1'b1;
                step();
                wr_done = 1'b0; rd_valid = 1'b0;
            end
            if (req_mid && i == 2) begin
                sdram_req = 1'b1;
                #2;
                check("yield_mid", yield == 1'b0 && command != CMD_IDLE,
                      $sformatf("yield=%0d cmd=%0d", yield, command), "yield=0 cmd!=0");
            end
            for (int j = 0; j < NUM_CH; j++) wb_head[j] = $urandom;
            if (rd) rd_valid = 1'b1; else wr_done = 1'b1;
            if (stop_at > 0 && i == nw - 1) rst_n = 1'b0;
            step();
            rd_valid = 1'b0; wr_done = 1'b0; rst_n = 1'b1;
        end
        if (stop_at > 0) begin
            for (int c = 0; c < NUM_CH; c++) m_ptr[c] = M_BASE[c];
            rr_next = 0;
        end else if (!rd) begin
            m_ptr[ch] = M_BASE[ch] + (m_ptr[ch] - M_BASE[ch] + n) % M_WORDS[ch];
        end
        @(negedge clk);
        check("burst_end", command == CMD_IDLE && yield == sdram_req,
              $sformatf("cmd=%0d yield=%0d", command, yield), $sformatf("cmd=0 yield=%0d", sdram_req));
        step();
        sdram_req = 1'b0;
    endtask

    task automatic yield_idle();
        sdram_req = 1'b1; rd_empty = '1; wb_empty = '1;
        repeat (3) begin
            @(negedge clk);
            check("yield_idle", yield == 1'b1 && command == CMD_IDLE,
                  $sformatf("yield=%0d cmd=%0d", yield, command), "yield=1 cmd=0");
            step();
        end
        sdram_req = 1'b0; rd_empty = '0; wb_empty = '0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_ptr[c] = M_BASE[c];
            wb_head[c] = '0;
        end
        rst_n = 1'b0; rd_valid = 1'b1; wr_done = 1'b1;
        rd_empty = '1; wb_empty = '1; wb_full = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd", command == CMD_IDLE, $sformatf("%0d", command), "0");
        check("rst_addr_chan", data_addr == '0 && chan == 3'd0, $sformatf("addr=%0h ch=%0d", data_addr, chan), "addr=0 ch=0");
        check("rst_strobes", rd_wrreq == '0 && wb_rdreq == '0 && yield == 1'b0,
              $sformatf("rd=%b wb=%b yield=%0d", rd_wrreq, wb_rdreq, yield), "rd=0 wb=0 yield=0");
        step();
        rd_valid = 1'b0; wr_done = 1'b0;
        rd_empty = '0; wb_empty = '0; wb_full = '0;
        rst_n = 1'b1;
        mon_on = 1'b1;
        step();

        issue(2'b01, 2'b01, 2'b00, 0, 1'b0);
        repeat (5) issue(2'b00, 2'b00, 2'b01, 0, 1'b0);
        issue(2'b00, 2'b00, 2'b10, 0, 1'b0);
        issue(2'b00, 2'b00, 2'b10, 4, 1'b0);
        issue(2'b00, 2'b00, 2'b10, 0, 1'b0);
        repeat (4) issue(2'b11, 2'b11, 2'b00, 0, 1'b0);
        issue(2'b11, 2'b11, 2'b11, 0, 1'b0);
        yield_idle();
        issue(2'b10, 2'b10, 2'b00, 0, 1'b1);
        issue(2'b00, 2'b00, 2'b00, 0, 1'b0);

        for (int t = 0; t < 70; t++) begin
            int stop;
            if ($urandom_range(1) == 1) begin
                rd_valid = 1'b1; wr_done = 1'b1;
                step();
                rd_valid = 1'b0; wr_done = 1'b0;
            end
            stop = ($urandom_range(9) == 0) ? int'($urandom_range(1, 8)) : 0;
            issue(NUM_CH'($urandom), NUM_CH'($urandom), NUM_CH'($urandom), stop, $urandom_range(7) == 0);
        end

        repeat (5) step();
        check("drain", grant_q.size() == 0 && word_q.size() == 0,
              $sformatf("grants=%0d words=%0d", grant_q.size(), word_q.size()), "grants=0 words=0");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
